// File: rtl/raster_zctl.sv
// Z-buffered fragment read-modify-write sequencer with full-buffer clear sweep.
// Define RASTER_ZCTL_STATS_EN to add saturating pass/fail fragment counters.
module raster_zctl #(
    parameter int H_RES  = 320,
    parameter int V_RES  = 240,
    parameter int AW     = 17,
    parameter int RD_LAT = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          frag_valid,
    output logic          frag_ready,
    input  logic [8:0]    frag_x,
    input  logic [7:0]    frag_y,
    input  logic [17:0]   frag_z,
    input  logic [15:0]   frag_color,
    input  logic          clear_start,
    output logic          clear_busy,
    output logic          clear_done,
    output logic [AW-1:0] ram_raddr,
    input  logic [17:0]   ram_rdata_z,
    output logic [AW-1:0] ram_waddr,
    output logic          ram_wren,
    output logic [15:0]   ram_wcolor,
`ifdef RASTER_ZCTL_STATS_EN
    output logic [31:0]   stat_pass,
    output logic [31:0]   stat_fail,
`endif
    output logic [17:0]   ram_wz
);

    localparam int DEPTH = H_RES * V_RES;
    localparam int LAST  = RD_LAT - 1;
    localparam logic [AW-1:0] CLR_END = AW'(DEPTH - 1);
    localparam logic [AW-1:0] H_RES_A = AW'(H_RES);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, CLEAR} state_t;

    state_t              state;
    logic [AW-1:0]       clr_cnt;
    logic [AW-1:0]       in_addr;
    logic                hazard;
    logic                accept;
    logic                zpass;
    logic                sweep_last;

    logic [RD_LAT-1:0]   stage_valid;
    logic [AW-1:0]       stage_addr  [RD_LAT];
    logic [17:0]         stage_z     [RD_LAT];
    logic [15:0]         stage_color [RD_LAT];

    // Sign-magnitude float ordering: +0 and -0 compare equal, negatives order by inverted magnitude.
    function automatic logic z_greater(input logic [17:0] a, input logic [17:0] b);
        logic a_zero;
        logic b_zero;
        a_zero = (a[16:0] == 17'd0);
        b_zero = (b[16:0] == 17'd0);
        if (a_zero && b_zero) begin
            return 1'b0;
        end
        if (a[17] != b[17]) begin
            return b[17];
        end
        if (!a[17]) begin
            return a[16:0] > b[16:0];
        end
        return a[16:0] < b[16:0];
    endfunction

    assign in_addr = AW'(frag_y) * H_RES_A + AW'(frag_x);

    // A fragment may not enter while any in-flight stage targets the same pixel,
    // so its read always observes the earlier fragment's write.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < RD_LAT; i++) begin
            if (stage_valid[i] && (stage_addr[i] == in_addr)) begin
                hazard = 1'b1;
            end
        end
    end

    assign frag_ready = (state == RUN) && !clear_done && !clear_start && !hazard;
    assign accept     = frag_valid && frag_ready;
    assign ram_raddr  = (state == RUN) ? in_addr : '0;
    assign zpass      = z_greater(stage_z[LAST], ram_rdata_z);
    assign sweep_last = (state == CLEAR) && (clr_cnt == CLR_END);

    always_comb begin
        ram_wren   = 1'b0;
        ram_waddr  = '0;
        ram_wcolor = '0;
        ram_wz     = '0;
        if (state == CLEAR) begin
            ram_wren  = 1'b1;
            ram_waddr = clr_cnt;
        end else if (stage_valid[LAST]) begin
            ram_wren   = zpass;
            ram_waddr  = stage_addr[LAST];
            ram_wcolor = stage_color[LAST];
            ram_wz     = stage_z[LAST];
        end
    end

    // Stage k holds the fragment whose Z read was issued k+1 cycles ago.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_valid <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                stage_addr[i]  <= '0;
                stage_z[i]     <= '0;
                stage_color[i] <= '0;
            end
        end else begin
            stage_valid[0] <= accept;
            stage_addr[0]  <= in_addr;
            stage_z[0]     <= frag_z;
            stage_color[0] <= frag_color;
            for (int i = 1; i < RD_LAT; i++) begin
                stage_valid[i] <= stage_valid[i-1];
                stage_addr[i]  <= stage_addr[i-1];
                stage_z[i]     <= stage_z[i-1];
                stage_color[i] <= stage_color[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            clr_cnt    <= '0;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            case (state)
                IDLE: begin
                    state <= RUN;
                end
                RUN: begin
                    if (clear_start) begin
                        state      <= DRAIN;
                        clear_busy <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (stage_valid == '0) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                    end
                end
                CLEAR: begin
                    if (sweep_last) begin
                        state      <= RUN;
                        clr_cnt    <= '0;
                        clear_busy <= 1'b0;
                        clear_done <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef RASTER_ZCTL_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_pass <= '0;
            stat_fail <= '0;
        end else if (sweep_last) begin
            stat_pass <= '0;
            stat_fail <= '0;
        end else if (stage_valid[LAST]) begin
            if (zpass) begin
                if (stat_pass != '1) begin
                    stat_pass <= stat_pass + 1'b1;
                end
            end else begin
                if (stat_fail != '1) begin
                    stat_fail <= stat_fail + 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_raster_zctl.sv
// Directed bench for raster_zctl: clear sweep, Z pass/fail, hazard stall, streaming, clear mid-stream.
module tb_raster_zctl;

    localparam int H_RES  = 320;
    localparam int V_RES  = 8;
    localparam int AW     = 17;
    localparam int RD_LAT = 2;
    localparam int DEPTH  = H_RES * V_RES;

    typedef struct {
        logic [AW-1:0] addr;
        logic [17:0]   z;
        logic [15:0]   color;
        int            cyc;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          frag_valid;
    logic          frag_ready;
    logic [8:0]    frag_x;
    logic [7:0]    frag_y;
    logic [17:0]   frag_z;
    logic [15:0]   frag_color;
    logic          clear_start;
    logic          clear_busy;
    logic          clear_done;
    logic [AW-1:0] ram_raddr;
    logic [17:0]   ram_rdata_z;
    logic [AW-1:0] ram_waddr;
    logic          ram_wren;
    logic [15:0]   ram_wcolor;
    logic [17:0]   ram_wz;
`ifdef RASTER_ZCTL_STATS_EN
    logic [31:0]   stat_pass;
    logic [31:0]   stat_fail;
`endif

    logic          pre_en;
    logic [11:0]   pre_addr;
    logic [17:0]   pre_z;

    logic [17:0]   zmem    [0:4095];
    logic [17:0]   rd_pipe [RD_LAT];
    wr_t           wr_q[$];
    int            acc_q[$];
    int            cyc = 0;
    int            done_count = 0;
    int            done_cyc = 0;
    int            total_checks = 0;
    int            bad_checks = 0;

    always #5 clk = ~clk;

    raster_zctl #(.H_RES(H_RES), .V_RES(V_RES), .AW(AW), .RD_LAT(RD_LAT)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .frag_valid(frag_valid),
        .frag_ready(frag_ready),
        .frag_x(frag_x),
        .frag_y(frag_y),
        .frag_z(frag_z),
        .frag_color(frag_color),
        .clear_start(clear_start),
        .clear_busy(clear_busy),
        .clear_done(clear_done),
        .ram_raddr(ram_raddr),
        .ram_rdata_z(ram_rdata_z),
        .ram_waddr(ram_waddr),
        .ram_wren(ram_wren),
        .ram_wcolor(ram_wcolor),
`ifdef RASTER_ZCTL_STATS_EN
        .stat_pass(stat_pass),
        .stat_fail(stat_fail),
`endif
        .ram_wz(ram_wz)
    );

    // Z RAM with RD_LAT read latency, plus logs of writes, accepts and clear_done pulses.
    assign ram_rdata_z = rd_pipe[RD_LAT-1];

    always @(posedge clk) begin
        if (pre_en) begin
            zmem[pre_addr] <= pre_z;
        end
        if (ram_wren) begin
            zmem[ram_waddr[11:0]] <= ram_wz;
            wr_q.push_back('{addr: ram_waddr, z: ram_wz, color: ram_wcolor, cyc: cyc});
        end
        rd_pipe[0] <= zmem[ram_raddr[11:0]];
        for (int i = 1; i < RD_LAT; i++) begin
            rd_pipe[i] <= rd_pipe[i-1];
        end
        if (frag_valid && frag_ready) begin
            acc_q.push_back(cyc);
        end
        if (clear_done) begin
            done_count <= done_count + 1;
            done_cyc   <= cyc;
        end
        cyc <= cyc + 1;
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        total_checks++;
        if (actual !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Called at a negedge; holds the fragment until accepted and returns at the following negedge.
    task automatic applyStimulus(input logic [8:0] x, input logic [7:0] y, input logic [17:0] z,
                                 input logic [15:0] c, input int max_wait, output int stalls);
        bit acc;
        frag_valid = 1'b1;
        frag_x     = x;
        frag_y     = y;
        frag_z     = z;
        frag_color = c;
        stalls     = 0;
        acc        = 1'b0;
        for (int i = 0; i < max_wait && !acc; i++) begin
            #1;
            acc = frag_ready;
            @(negedge clk);
            if (!acc) stalls++;
        end
        if (!acc) checkOutput("accept_timeout", 0, 1);
    endtask

    task automatic preload(input int a, input logic [17:0] z);
        pre_en   = 1'b1;
        pre_addr = 12'(a);
        pre_z    = z;
        @(negedge clk);
        pre_en   = 1'b0;
    endtask

    function automatic int clear_seq_errs(input int base);
        int errs = 0;
        for (int k = 0; k < DEPTH; k++) begin
            if (base + k >= wr_q.size()) begin
                errs++;
            end else if (int'(wr_q[base+k].addr) != k || wr_q[base+k].z != 18'd0 ||
                         wr_q[base+k].color != 16'd0) begin
                errs++;
            end
        end
        return errs;
    endfunction

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int st, st2, base_w, base_a, base_d, errs, stall_sum, n_exp;
        logic [17:0] zi;

        reset_n = 1'b0; frag_valid = 1'b0; frag_x = '0; frag_y = '0; frag_z = '0;
        frag_color = '0; clear_start = 1'b0; pre_en = 1'b0; pre_addr = '0; pre_z = '0;
        repeat (3) @(negedge clk);

        checkOutput("rst_ready", int'(frag_ready), 0);
        checkOutput("rst_busy", int'(clear_busy), 0);
        checkOutput("rst_done", int'(clear_done), 0);
        checkOutput("rst_wren", int'(ram_wren), 0);
        checkOutput("rst_waddr", int'(ram_waddr), 0);
        checkOutput("rst_raddr", int'(ram_raddr), 0);
        checkOutput("rst_wz", int'(ram_wz), 0);

        reset_n = 1'b1;
        #1 checkOutput("ready_idle", int'(frag_ready), 0);
        @(negedge clk);
        checkOutput("ready_run", int'(frag_ready), 1);

        // Test 1: full clear, with a second clear_start while busy that must be ignored.
        base_w = wr_q.size();
        base_d = done_count;
        clear_start = 1'b1;
        @(negedge clk);
        clear_start = 1'b0;
        checkOutput("busy_start", int'(clear_busy), 1);
        for (int i = 0; i < DEPTH + 20 && !clear_done; i++) begin
            clear_start = (i == 100);
            if (i == 50) begin
                checkOutput("busy_mid", int'(clear_busy), 1);
                checkOutput("ready_mid", int'(frag_ready), 0);
            end
            @(negedge clk);
        end
        clear_start = 1'b0;
        checkOutput("clear_done_seen", int'(clear_done), 1);
        checkOutput("ready_at_done", int'(frag_ready), 0);
        checkOutput("busy_at_done", int'(clear_busy), 0);
        @(negedge clk);
        checkOutput("ready_after_done", int'(frag_ready), 1);
        checkOutput("done_one_cycle", int'(clear_done), 0);
        repeat (3) @(negedge clk);
        checkOutput("clear_done_count", done_count - base_d, 1);
        checkOutput("clear_write_count", wr_q.size() - base_w, DEPTH);
        checkOutput("clear_seq_errs", clear_seq_errs(base_w), 0);

        // Test 2: pass, pixel (3,2) -> 643.
        preload(643, 18'h00100);
        base_w = wr_q.size();
        base_a = acc_q.size();
        applyStimulus(9'd3, 8'd2, 18'h00200, 16'hF800, 20, st);
        frag_valid = 1'b0;
        checkOutput("pass_stalls", st, 0);
        checkOutput("pass_wren_early", int'(ram_wren), 0);
        @(negedge clk);
        checkOutput("pass_wren", int'(ram_wren), 1);
        checkOutput("pass_waddr", int'(ram_waddr), 643);
        checkOutput("pass_wcolor", int'(ram_wcolor), 'hF800);
        checkOutput("pass_wz", int'(ram_wz), 'h200);
        repeat (4) @(negedge clk);
        checkOutput("pass_write_count", wr_q.size() - base_w, 1);
        if (wr_q.size() > base_w && acc_q.size() > base_a)
            checkOutput("pass_latency", wr_q[base_w].cyc - acc_q[base_a], RD_LAT);

        // Test 3: equal Z and smaller Z fail; positive beats a negative stored Z.
        base_w = wr_q.size();
        applyStimulus(9'd3, 8'd2, 18'h00200, 16'h07E0, 20, st);
        frag_valid = 1'b0;
        @(negedge clk);
        checkOutput("equal_wren", int'(ram_wren), 0);
        repeat (3) @(negedge clk);
        applyStimulus(9'd3, 8'd2, 18'h00180, 16'h07E0, 20, st);
        frag_valid = 1'b0;
        @(negedge clk);
        checkOutput("less_wren", int'(ram_wren), 0);
        repeat (3) @(negedge clk);
        checkOutput("fail_write_count", wr_q.size() - base_w, 0);
        preload(10, 18'h20100);
        applyStimulus(9'd10, 8'd0, 18'h00000, 16'h001F, 20, st);
        frag_valid = 1'b0;
        @(negedge clk);
        checkOutput("neg_wren", int'(ram_wren), 1);
        checkOutput("neg_waddr", int'(ram_waddr), 10);
        repeat (3) @(negedge clk);

        // Test 4: same-pixel back-to-back fragments.
        base_w = wr_q.size();
        base_a = acc_q.size();
        applyStimulus(9'd5, 8'd5, 18'h00300, 16'h1234, 20, st);
        applyStimulus(9'd5, 8'd5, 18'h00250, 16'h4321, 20, st2);
        frag_valid = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("hazard_first_stalls", st, 0);
        checkOutput("hazard_second_stalls", st2, RD_LAT);
        if (acc_q.size() >= base_a + 2)
            checkOutput("hazard_spacing", acc_q[base_a+1] - acc_q[base_a], RD_LAT + 1);
        checkOutput("hazard_write_count", wr_q.size() - base_w, 1);
        if (wr_q.size() > base_w) begin
            checkOutput("hazard_waddr", int'(wr_q[base_w].addr), 1605);
            checkOutput("hazard_wz", int'(wr_q[base_w].z), 'h300);
        end

        // Test 5: 100 distinct pixels back-to-back; every fifth has z=0 and fails.
        base_w = wr_q.size();
        base_a = acc_q.size();
        stall_sum = 0;
        for (int i = 0; i < 100; i++) begin
            zi = (i % 5 == 4) ? 18'd0 : 18'(32'h100 + i);
            applyStimulus(9'(i), 8'd6, zi, 16'(i * 3), 5, st);
            stall_sum += st;
        end
        frag_valid = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("stream_stalls", stall_sum, 0);
        checkOutput("stream_write_count", wr_q.size() - base_w, 80);
        errs  = 0;
        n_exp = 0;
        for (int i = 0; i < 100; i++) begin
            if (i % 5 != 4) begin
                if (base_w + n_exp >= wr_q.size() || base_a + i >= acc_q.size()) begin
                    errs++;
                end else if (int'(wr_q[base_w+n_exp].addr) != 1920 + i ||
                             int'(wr_q[base_w+n_exp].z) != 'h100 + i ||
                             wr_q[base_w+n_exp].color != 16'(i * 3) ||
                             wr_q[base_w+n_exp].cyc - acc_q[base_a+i] != RD_LAT) begin
                    errs++;
                end
                n_exp++;
            end
        end
        checkOutput("stream_errs", errs, 0);

        // Test 6: clear requested with two fragments in flight and a third waiting.
        base_w = wr_q.size();
        base_d = done_count;
        applyStimulus(9'd100, 8'd0, 18'h00050, 16'hAAAA, 20, st);
        applyStimulus(9'd101, 8'd0, 18'h00050, 16'hBBBB, 20, st);
        clear_start = 1'b1;
        frag_x = 9'd200; frag_y = 8'd0; frag_z = 18'h00040; frag_color = 16'hCCCC;
        #1 checkOutput("ready_on_clear", int'(frag_ready), 0);
        @(negedge clk);
        clear_start = 1'b0;
        applyStimulus(9'd200, 8'd0, 18'h00040, 16'hCCCC, DEPTH + 50, st);
        frag_valid = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("mid_write_count", wr_q.size() - base_w, DEPTH + 3);
        checkOutput("mid_done_count", done_count - base_d, 1);
        if (wr_q.size() >= base_w + DEPTH + 3) begin
            checkOutput("mid_frag1_addr", int'(wr_q[base_w].addr), 100);
            checkOutput("mid_frag2_addr", int'(wr_q[base_w+1].addr), 101);
            checkOutput("mid_clear_errs", clear_seq_errs(base_w + 2), 0);
            checkOutput("mid_frag3_addr", int'(wr_q[base_w+DEPTH+2].addr), 200);
        end
        if (acc_q.size() > 0)
            checkOutput("mid_accept_after_done", acc_q[acc_q.size()-1], done_cyc + 1);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
